// File: rtl/data_mem_io_if.sv
// Core load/store bus plus the TX byte stream of the data memory / IO block.
// master = core and byte sink side, slave = data_mem_io.
interface data_mem_io_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output memwrite, addr, writedata, tx_ready,
        input  readdata, tx_valid, tx_data
    );

    modport slave (
        input  memwrite, addr, writedata, tx_ready,
        output readdata, tx_valid, tx_data
    );
endinterface

// File: rtl/data_mem_io.sv
// Data RAM plus memory-mapped IO: LED register, free-running timer with
// compare interrupt, and a byte TX FIFO. Every access completes in the cycle
// it is presented; loads are combinational.
module data_mem_io #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_io_if.slave  bus,
    output logic [7:0]    leds,
    output logic          irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FIFO_FULL = (PW+1)'(FIFO_DEPTH);

    // Word addresses (byte address >> 2) of the IO registers.
    localparam logic [29:0] W_LED    = 30'h3FFF_FFC0;
    localparam logic [29:0] W_TCOUNT = 30'h3FFF_FFC1;
    localparam logic [29:0] W_TCMP   = 30'h3FFF_FFC2;
    localparam logic [29:0] W_TX     = 30'h3FFF_FFC3;
    localparam logic [29:0] W_IRQ    = 30'h3FFF_FFC4;

    logic [29:0]    word;
    logic           ram_hit;
    logic [AW-1:0]  ram_idx;
    logic           unused_addr_lsbs;

    assign word             = bus.addr[31:2];
    assign ram_hit          = (bus.addr[31:AW+2] == '0);
    assign ram_idx          = bus.addr[AW+1:2];
    assign unused_addr_lsbs = ^bus.addr[1:0];

    logic ram_we, led_we, tcount_we, tcmp_we, tx_we, irq_we;
    assign ram_we    = bus.memwrite && ram_hit;
    assign led_we    = bus.memwrite && (word == W_LED);
    assign tcount_we = bus.memwrite && (word == W_TCOUNT);
    assign tcmp_we   = bus.memwrite && (word == W_TCMP);
    assign tx_we     = bus.memwrite && (word == W_TX);
    assign irq_we    = bus.memwrite && (word == W_IRQ);

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] tcount, tcmp;
    logic        match;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic          empty, full, pop, push_ok, drop;

    assign match   = (tcmp != '0) && (tcount == tcmp);
    assign empty   = (count == '0);
    assign full    = (count == FIFO_FULL);
    assign pop     = !empty && bus.tx_ready;
    assign push_ok = tx_we && (!full || pop);
    assign drop    = tx_we && !push_ok;

    // Data RAM write port; writes are held off while reset is asserted.
    // NOTE: the RAM array has no reset branch - clearing a memory is costly and contents are only defined by stores.
    always_ff @(posedge clk) begin
        if (reset && ram_we)
            ram[ram_idx] <= bus.writedata;
    end

    // LED, timer and compare registers.
    // NOTE: sequential state uses non-blocking (<=); combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds   <= '0;
            tcount <= '0;
            tcmp   <= '0;
        end else begin
            if (led_we)  leds <= bus.writedata[7:0];
            if (tcmp_we) tcmp <= bus.writedata;
            tcount <= tcount_we ? bus.writedata : tcount + 32'd1;
        end
    end

    // Sticky interrupt: a match in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            irq <= 1'b0;
        else if (match)
            irq <= 1'b1;
        else if (irq_we && bus.writedata[0])
            irq <= 1'b0;
    end

    // TX FIFO storage, cleared so tx_data reads 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                fifo_mem[i] <= '0;
        end else if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.writedata[7:0];
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow (a drop beats a clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (tx_we && bus.writedata[8])
                overflow <= 1'b0;
        end
    end

    assign bus.tx_valid = !empty;
    assign bus.tx_data  = fifo_mem[rd_ptr];

    // Zero-latency load mux; unmapped addresses read as 0.
    // NOTE: readdata gets a default first so no path through this block infers a latch.
    always_comb begin
        bus.readdata = '0;
        if (ram_hit) begin
            bus.readdata = ram[ram_idx];
        end else begin
            case (word)
                W_LED:    bus.readdata = {24'b0, leds};
                W_TCOUNT: bus.readdata = tcount;
                W_TCMP:   bus.readdata = tcmp;
                W_TX:     bus.readdata = {28'b0, overflow, full, empty, 1'b0};
                W_IRQ:    bus.readdata = {31'b0, irq};
                default:  bus.readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_io.sv
// Scoreboard bench for data_mem_io: a driver applies one access per cycle and
// pushes the expected response from a behavioural model; a monitor compares
// the DUT outputs and the TX byte stream independently.
module tb_data_mem_io;
    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] leds;
    logic       irq;

    data_mem_io_if bus();

    data_mem_io #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .leds  (leds),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic [7:0]  leds;
        logic        irq;
        logic        valid;
        logic [7:0]  head;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] out_q[$];
    int         n_pass  = 0;
    int         n_total = 0;

    // Behavioural model state.
    logic [31:0] m_ram [RAM_WORDS];
    logic [7:0]  m_leds;
    logic [31:0] m_tcount, m_tcmp;
    logic        m_irq, m_ovf;
    logic [7:0]  m_fifo[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, expv);
    endtask

    task automatic model_reset();
        m_leds   = '0;
        m_tcount = '0;
        m_tcmp   = '0;
        m_irq    = 1'b0;
        m_ovf    = 1'b0;
        m_fifo.delete();
        out_q.delete();
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a < 32'(4 * RAM_WORDS)) return m_ram[a[7:2]];
        case ({a[31:2], 2'b00})
            32'hFFFF_FF00: return {24'b0, m_leds};
            32'hFFFF_FF04: return m_tcount;
            32'hFFFF_FF08: return m_tcmp;
            32'hFFFF_FF0C: return {28'b0, m_ovf, m_fifo.size() == FIFO_DEPTH, m_fifo.size() == 0, 1'b0};
            32'hFFFF_FF10: return {31'b0, m_irq};
            default:       return 32'h0;
        endcase
    endfunction

    // Apply the effect of one rising edge to the model.
    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy);
        logic        pop, match, accept, irq_n, ovf_n;
        logic [31:0] cnt_n;
        pop    = (m_fifo.size() != 0) && rdy;
        match  = (m_tcmp != 0) && (m_tcount == m_tcmp);
        cnt_n  = m_tcount + 1;
        irq_n  = m_irq;
        ovf_n  = m_ovf;
        accept = 1'b0;
        if (we) begin
            if (a < 32'(4 * RAM_WORDS)) m_ram[a[7:2]] = wd;
            case ({a[31:2], 2'b00})
                32'hFFFF_FF00: m_leds = wd[7:0];
                32'hFFFF_FF04: cnt_n = wd;
                32'hFFFF_FF08: m_tcmp = wd;
                32'hFFFF_FF0C: begin
                    accept = (m_fifo.size() < FIFO_DEPTH) || pop;
                    if (wd[8]) ovf_n = 1'b0;
                    if (!accept) ovf_n = 1'b1;
                end
                32'hFFFF_FF10: if (wd[0]) irq_n = 1'b0;
                default: ;
            endcase
        end
        if (match) irq_n = 1'b1;
        if (pop) void'(m_fifo.pop_front());
        if (accept) begin
            m_fifo.push_back(wd[7:0]);
            out_q.push_back(wd[7:0]);
        end
        m_tcount = cnt_n;
        m_irq    = irq_n;
        m_ovf    = ovf_n;
    endtask

    // Drive one cycle of stimulus at the falling edge and queue its expectation.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic rdy, input logic rst_lvl);
        exp_t e;
        @(negedge clk);
        bus.memwrite  = we;
        bus.addr      = a;
        bus.writedata = wd;
        bus.tx_ready  = rdy;
        reset         = rst_lvl;
        if (!rst_lvl) model_reset();
        e.rd    = model_read(a);
        e.leds  = m_leds;
        e.irq   = m_irq;
        e.valid = (m_fifo.size() != 0);
        e.head  = e.valid ? m_fifo[0] : 8'h00;
        exp_q.push_back(e);
        if (rst_lvl) model_edge(we, a, wd, rdy);
    endtask

    // Monitor: per-cycle output comparison and TX byte scoreboard.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("readdata", bus.readdata, e.rd);
            check("leds", {24'b0, leds}, {24'b0, e.leds});
            check("irq", {31'b0, irq}, {31'b0, e.irq});
            check("tx_valid", {31'b0, bus.tx_valid}, {31'b0, e.valid});
            if (e.valid) check("tx_head", {24'b0, bus.tx_data}, {24'b0, e.head});
        end
        if (reset && bus.tx_valid && bus.tx_ready) begin
            if (out_q.size() == 0) begin
                n_total++;
                $display("FAIL tx_extra: got byte %02h expected none", bus.tx_data);
            end else begin
                check("tx_byte", {24'b0, bus.tx_data}, {24'b0, out_q.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0] a, wd;
        bus.memwrite  = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;
        bus.tx_ready  = 1'b0;
        model_reset();

        // Reset state.
        cycle(0, 32'hFFFF_FF0C, 0, 0, 0);
        #2 check("rst_txstat", bus.readdata, 32'h2);
        check("rst_leds", {24'b0, leds}, 32'h0);
        cycle(0, 32'hFFFF_FF04, 0, 0, 0);
        #2 check("rst_tcount", bus.readdata, 32'h0);

        // Initialise the whole RAM so every later load is defined.
        for (int i = 0; i < RAM_WORDS; i++) cycle(1, 32'(i * 4), $urandom, 0, 1);

        // Store then load; unmapped load.
        cycle(1, 32'h10, 32'hDEAD_BEEF, 0, 1);
        cycle(0, 32'h10, 0, 0, 1);
        #2 check("ram_load", bus.readdata, 32'hDEAD_BEEF);
        cycle(0, 32'h400, 0, 0, 1);
        #2 check("unmapped", bus.readdata, 32'h0);

        // Timer compare and interrupt clear.
        cycle(1, 32'hFFFF_FF04, 0, 0, 1);
        cycle(1, 32'hFFFF_FF08, 5, 0, 1);
        repeat (8) cycle(0, 32'hFFFF_FF10, 0, 0, 1);
        cycle(0, 32'hFFFF_FF10, 0, 0, 1);
        #2 check("irq_set", bus.readdata, 32'h1);
        cycle(1, 32'hFFFF_FF10, 1, 0, 1);
        cycle(0, 32'hFFFF_FF10, 0, 0, 1);
        #2 check("irq_clear", {31'b0, irq}, 32'h0);
        cycle(1, 32'hFFFF_FF08, 0, 0, 1);
        cycle(1, 32'hFFFF_FF04, 32'hFFFF_FFFC, 0, 1);
        repeat (8) cycle(0, 32'hFFFF_FF04, 0, 0, 1);
        #2 check("irq_disabled", {31'b0, irq}, 32'h0);

        // Counter wrap.
        cycle(1, 32'hFFFF_FF04, 32'hFFFF_FFFE, 0, 1);
        cycle(0, 32'hFFFF_FF04, 0, 0, 1);
        cycle(0, 32'hFFFF_FF04, 0, 0, 1);
        #2 check("tcount_max", bus.readdata, 32'hFFFF_FFFF);
        cycle(0, 32'hFFFF_FF04, 0, 0, 1);
        #2 check("tcount_wrap", bus.readdata, 32'h0);

        // Fill, overflow, then drain.
        for (int i = 0; i < 5; i++) cycle(1, 32'hFFFF_FF0C, 32'h41 + i, 0, 1);
        cycle(0, 32'hFFFF_FF0C, 0, 0, 1);
        #2 check("full_ovf", bus.readdata, 32'hC);
        check("head_41", {24'b0, bus.tx_data}, 32'h41);
        repeat (4) cycle(0, 32'hFFFF_FF0C, 0, 1, 1);
        cycle(0, 32'hFFFF_FF0C, 0, 0, 1);
        #2 check("drained_ovf", bus.readdata, 32'hA);

        // Push into a full FIFO while it pops: accepted, emitted last.
        cycle(1, 32'hFFFF_FF0C, 32'h141, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 32'hFFFF_FF0C, 32'h42 + i, 0, 1);
        cycle(1, 32'hFFFF_FF0C, 32'h55, 1, 1);
        cycle(0, 32'hFFFF_FF0C, 0, 0, 1);
        #2 check("full_no_ovf", bus.readdata, 32'h4);
        repeat (3) cycle(0, 32'hFFFF_FF0C, 0, 1, 1);
        cycle(0, 32'hFFFF_FF0C, 0, 1, 1);
        #2 check("last_55", {24'b0, bus.tx_data}, 32'h55);
        cycle(0, 32'hFFFF_FF0C, 0, 0, 1);
        #2 check("empty_again", bus.readdata, 32'h2);

        // Reset mid-operation.
        for (int i = 0; i < 3; i++) cycle(1, 32'hFFFF_FF0C, 32'h61 + i, 0, 1);
        cycle(1, 32'hFFFF_FF00, 32'hA5, 0, 1);
        cycle(0, 32'hFFFF_FF00, 0, 0, 1);
        #2 check("leds_a5", {24'b0, leds}, 32'hA5);
        cycle(0, 32'h10, 0, 0, 0);
        #2 check("rst_txvalid", {31'b0, bus.tx_valid}, 32'h0);
        check("rst_leds0", {24'b0, leds}, 32'h0);
        check("rst_ram", bus.readdata, 32'hDEAD_BEEF);
        cycle(1, 32'h10, 32'h1234_5678, 0, 0);
        cycle(0, 32'hFFFF_FF04, 0, 0, 1);
        #2 check("tcount_restart", bus.readdata, 32'h0);
        cycle(0, 32'h10, 0, 0, 1);
        #2 check("ram_kept", bus.readdata, 32'hDEAD_BEEF);

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            wd = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: a = 32'($urandom_range(0, RAM_WORDS - 1) * 4);
                3:       a = 32'hFFFF_FF00;
                4:       begin a = 32'hFFFF_FF04; if ($urandom_range(0, 3) != 0) wd = $urandom_range(0, 30); end
                5:       begin a = 32'hFFFF_FF08; wd = $urandom_range(0, 40); end
                6, 7:    begin a = 32'hFFFF_FF0C; wd = wd & 32'h1FF; end
                8:       a = 32'hFFFF_FF10;
                default: case ($urandom_range(0, 3))
                             0:       a = 32'h0000_0400;
                             1:       a = 32'h8000_0000;
                             2:       a = 32'hFFFF_FF14;
                             default: a = 32'hFFFF_FEFC;
                         endcase
            endcase
            a = a | 32'($urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), a, wd, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 299) != 0));
        end

        // Drain whatever remains, bounded.
        for (int i = 0; i < 40 && m_fifo.size() != 0; i++) cycle(0, 32'h400, 0, 1, 1);
        cycle(0, 32'h400, 0, 0, 1);
        #2 check("tx_drained", {31'b0, bus.tx_valid}, 32'h0);
        check("tx_pending", 32'(out_q.size()), 32'h0);
        repeat (2) @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
